// File: rtl/regfile_dump_reader.sv
// -----------------------------------------------------------------------------
// regfile_dump_reader
//
// Debug read-out sequencer for a register file. A start pulse makes it sweep
// the register file's asynchronous read port over every address. Each word is
// captured and then streamed out on a valid/ready interface, together with its
// index and a last marker.
//
// Optional build macro:
//   REGDUMP_SKIP_ZERO_EN - the sweep starts at address 1, so register 0 is
//                          never read or emitted. When the macro is undefined,
//                          the sweep starts at address 0.
//
// Ports:
//   clk        rising-edge clock shared with the register file
//   rst_n      asynchronous active-low reset
//   start      request a full dump (sampled only in IDLE)
//   abort      terminate a dump in progress; no done pulse
//   rd_addr    address driven to the register file read port
//   rd_data    combinational read data for rd_addr
//   out_valid  out_data/out_index/out_last hold a word
//   out_ready  sink accepts the word when high with out_valid
//   out_data   captured register value
//   out_index  address out_data was read from
//   out_last   high with the final word of the dump
//   busy       high while a dump is in progress (LOAD or SEND)
//   done       one-cycle pulse after the last word is accepted
// -----------------------------------------------------------------------------
module regfile_dump_reader #(
   parameter int unsigned NUM_REGS = 32,
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned DATA_W   = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [ADDR_W-1:0] out_index,
   output logic              out_last,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      SEND = 2'd2
   } state_t;

`ifdef REGDUMP_SKIP_ZERO_EN
   localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(1);
`else
   localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(0);
`endif
   localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_REGS - 1);

   state_t state;
   state_t state_next;

   // out_valid is always high in SEND, so this is the accept condition there.
   logic handshake;
   assign handshake = out_valid && out_ready;

   // NOTE: sequential state uses non-blocking assignments, so every flop
   // samples values from before the edge, whatever order the blocks run in.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      // NOTE: the default is assigned first, so no path leaves state_next
      // unassigned and no latch is inferred.
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = LOAD;
         LOAD:    state_next = SEND;
         SEND:    if (handshake) state_next = out_last ? IDLE : LOAD;
         default: state_next = IDLE;
      endcase
      // abort takes priority over start and over a handshake in the same cycle.
      if (abort) state_next = IDLE;
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_addr   <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_index <= '0;
         out_last  <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         if (abort) begin
            // The word that is pending is dropped and not counted as delivered.
            out_valid <= 1'b0;
            rd_addr   <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (start) rd_addr <= FIRST_ADDR;
               end
               LOAD: begin
                  // Any register-file write at this same edge is not visible,
                  // so the old value is the one captured.
                  out_data  <= rd_data;
                  out_index <= rd_addr;
                  out_last  <= (rd_addr == LAST_ADDR);
                  out_valid <= 1'b1;
               end
               SEND: begin
                  if (handshake) begin
                     out_valid <= 1'b0;
                     // rd_addr stops at LAST_ADDR, so it never wraps.
                     if (out_last) done    <= 1'b1;
                     else          rd_addr <= rd_addr + ADDR_W'(1);
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// -----------------------------------------------------------------------------
// tb_regfile_dump_reader
//
// Self-checking bench for regfile_dump_reader. It contains a 32x32 register
// file model with an asynchronous read port and a dump-level reference model.
// The reference model is the list of addresses a full dump must emit, and
// each emitted word is compared with the register file contents.
// Define REGDUMP_SKIP_ZERO_EN here as well when building the skip-zero variant.
// -----------------------------------------------------------------------------
module tb_regfile_dump_reader;

   localparam int NUM_REGS = 32;
   localparam int ADDR_W   = 5;
   localparam int DATA_W   = 32;
`ifdef REGDUMP_SKIP_ZERO_EN
   localparam int FIRST    = 1;
`else
   localparam int FIRST    = 0;
`endif
   localparam int WORDS    = NUM_REGS - FIRST;
   localparam int BOUND    = 2000;

   logic              clk;
   logic              rst_n;
   logic              start;
   logic              abort;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [ADDR_W-1:0] out_index;
   logic              out_last;
   logic              busy;
   logic              done;

   logic [DATA_W-1:0] regs [NUM_REGS];
   assign rd_data = regs[rd_addr];

   int checks = 0;
   int errors = 0;

   regfile_dump_reader #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .abort     (abort),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_index (out_index),
      .out_last  (out_last),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_valid"}, 64'(out_valid), 64'd0);
      check({tag, "_data"},  64'(out_data),  64'd0);
      check({tag, "_index"}, 64'(out_index), 64'd0);
      check({tag, "_last"},  64'(out_last),  64'd0);
      check({tag, "_addr"},  64'(rd_addr),   64'd0);
      check({tag, "_busy"},  64'(busy),      64'd0);
      check({tag, "_done"},  64'(done),      64'd0);
   endtask

   // pattern: 0 = 32'hA5000000 + i, 1 = random contents
   task automatic fill_regs(input int pattern);
      for (int i = 0; i < NUM_REGS; i++)
         regs[i] = (pattern == 0) ? 32'hA500_0000 + 32'(i) : $urandom;
   endtask

   // Step through negedges until the selected condition holds.
   // mode 0: word k is presented; mode 1: LOAD with rd_addr == k.
   task automatic wait_for(input int mode, input int k, input string name);
      bit hit = 1'b0;
      for (int n = 0; n < BOUND && !hit; n++) begin
         @(negedge clk); #1;
         if (mode == 0) hit = out_valid && (int'(out_index) == k);
         else           hit = busy && !out_valid && (int'(rd_addr) == k);
      end
      if (!hit) check({name, "_timeout"}, 64'd1, 64'd0);
   endtask

   // Full dump compared with the reference sequence FIRST..NUM_REGS-1.
   // exp_cycles < 0 means the edge count to done is not checked (random ready).
   task automatic run_dump(input bit rnd_ready, input bit extra_starts,
                           input int exp_words, input int exp_cycles, input string name);
      int exp_q[$];
      int n = 0;
      int got = 0;
      bit got_done = 1'b0;
      bit stalled = 1'b0;
      logic [DATA_W-1:0] p_data;
      logic [ADDR_W-1:0] p_index;
      logic              p_last;
      for (int i = FIRST; i < NUM_REGS; i++) exp_q.push_back(i);
      @(negedge clk);
      start = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);                       // start edge E0
      while (!got_done && n < BOUND) begin
         @(negedge clk);
         // Extra start pulses only while the dump cannot be in IDLE at the next edge.
         start = extra_starts && busy && !(out_valid && out_last) && (n % 3 == 1);
         out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         #1;
         if (stalled) begin
            check({name, "_hold_valid"}, 64'(out_valid), 64'd1);
            check({name, "_hold_word"}, {31'd0, p_last, p_index, p_data},
                  {31'd0, out_last, out_index, out_data});
         end
         if (done) begin
            got_done = 1'b1;
            check({name, "_words"}, 64'(got), 64'(exp_words));
            check({name, "_missing"}, 64'(exp_q.size()), 64'd0);
            check({name, "_busy_at_done"}, 64'(busy), 64'd0);
            if (exp_cycles >= 0) check({name, "_cycles"}, 64'(n), 64'(exp_cycles));
         end else if (out_valid && out_ready) begin
            got++;
            if (exp_q.size() == 0) begin
               check({name, "_extra_word"}, 64'(out_index), 64'hFFFF);
            end else begin
               int idx = exp_q.pop_front();
               check({name, "_index"}, 64'(out_index), 64'(idx));
               check({name, "_data"},  64'(out_data),  64'(regs[idx]));
               check({name, "_last"},  64'(out_last),  64'(idx == NUM_REGS - 1));
            end
         end
         stalled = out_valid && !out_ready;
         p_data  = out_data;
         p_index = out_index;
         p_last  = out_last;
         if (!got_done) begin
            @(posedge clk);
            n++;
         end
      end
      if (!got_done) check({name, "_done_timeout"}, 64'd1, 64'd0);
      start = 1'b0;
      out_ready = 1'b1;
      @(negedge clk); #1;
      check({name, "_done_pulse_width"}, 64'(done), 64'd0);
      check({name, "_idle_after"}, 64'(busy), 64'd0);
   endtask

   typedef struct {
      int pattern;
      bit rnd_ready;
      bit extra_starts;
      int exp_words;
      int exp_cycles;
   } vec_t;

   vec_t vecs[5];

   initial begin
      vecs[0] = '{0, 1'b0, 1'b0, WORDS, 2 * WORDS};
      vecs[1] = '{0, 1'b1, 1'b0, WORDS, -1};
      vecs[2] = '{1, 1'b1, 1'b0, WORDS, -1};
      vecs[3] = '{1, 1'b0, 1'b1, WORDS, 2 * WORDS};
      vecs[4] = '{1, 1'b1, 1'b1, WORDS, -1};

      rst_n = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      out_ready = 1'b1;
      fill_regs(0);
      #3;
      check_idle_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      for (int v = 0; v < 5; v++) begin
         fill_regs(vecs[v].pattern);
         run_dump(vecs[v].rnd_ready, vecs[v].extra_starts, vecs[v].exp_words,
                  vecs[v].exp_cycles, $sformatf("vec%0d", v));
      end

      // Abort while word 10 is offered with ready high in the same cycle.
      fill_regs(0);
      @(negedge clk);
      start = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_for(0, 10, "abort_wait");
      abort = 1'b1;
      @(negedge clk); #1;
      abort = 1'b0;
      check("abort_valid", 64'(out_valid), 64'd0);
      check("abort_busy",  64'(busy),      64'd0);
      check("abort_addr",  64'(rd_addr),   64'd0);
      check("abort_done",  64'(done),      64'd0);
      @(negedge clk); #1;
      check("abort_done_later", 64'(done), 64'd0);
      run_dump(1'b0, 1'b0, WORDS, 2 * WORDS, "after_abort");

      // Register write at the LOAD edge of index 5: the old value is dumped.
      fill_regs(0);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_for(1, 5, "wr_wait");
      @(posedge clk);
      regs[5] <= 32'hDEAD_BEEF;             // write lands at the LOAD edge itself
      @(negedge clk); #1;
      check("wr_index", 64'(out_index), 64'd5);
      check("wr_old_data", 64'(out_data), 64'hA500_0005);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("wr_new_value", 64'(regs[5]), 64'hDEAD_BEEF);
      run_dump(1'b0, 1'b0, WORDS, 2 * WORDS, "after_write");

      // Asynchronous reset in the middle of a dump (index 20 presented).
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_for(0, 20, "rst_wait");
      rst_n = 1'b0;
      #1;
      check_idle_outputs("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk); #1;
      check("midrst_no_done", 64'(done), 64'd0);
      run_dump(1'b1, 1'b1, WORDS, -1, "after_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_dump_reader.md
# regfile_dump_reader

Debug read-out sequencer for the 32×32 register file. On a start pulse it walks the register file's asynchronous read port over every register address, captures each word, and streams it out on a valid/ready interface with index and last markers. It sits beside the datapath on a spare register-file read port, and feeds a debug/trace sink (UART bridge, testbench monitor).

## Interface
- NUM_REGS, 32, number of registers swept; addresses 0..NUM_REGS-1
- ADDR_W, 5, register address width; must satisfy 2^ADDR_W >= NUM_REGS
- DATA_W, 32, register data width

- clk  in  1  rising-edge clock shared with the register file
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request a full dump; sampled only in IDLE
- abort  in  1  terminate a dump in progress; returns to IDLE, no done
- rd_addr  out  ADDR_W  register address driven to the register file read port
- rd_data  in  DATA_W  combinational read data returned for rd_addr
- out_valid  out  1  out_data/out_index/out_last hold a word
- out_ready  in  1  sink accepts the word when high together with out_valid
- out_data  out  DATA_W  captured register value
- out_index  out  ADDR_W  address out_data was read from
- out_last  out  1  high with the final word of the dump
- busy  out  1  high in LOAD and SEND
- done  out  1  one-cycle pulse after the last word is accepted

## Operation
- States: IDLE, LOAD, SEND.
- IDLE: busy=0, out_valid=0. start=1 and abort=0 at an edge -> rd_addr<=first address, LOAD.
- LOAD: rd_addr stable; at the edge, out_data<=rd_data, out_index<=rd_addr, out_last<=(rd_addr==NUM_REGS-1), out_valid<=1 -> SEND.
- SEND: out_valid=1; out_data/out_index/out_last and rd_addr held stable until the handshake. On out_valid&&out_ready: out_valid<=0; if out_last -> done<=1, IDLE; else rd_addr<=rd_addr+1, LOAD.
- abort=1 in any state at an edge -> IDLE, out_valid<=0, done stays 0, rd_addr<=0. abort wins over start and over a simultaneous handshake, so the word is not counted as delivered.
- start while busy: ignored. start held high across done: a new dump begins from the IDLE edge that samples it.
- The captured value is whatever the register file returns in the LOAD cycle. A register-file write at that same edge is not visible; the old value is dumped. No coherency with the datapath beyond that.
- rd_addr never exceeds NUM_REGS-1; no wrap-around is ever issued.

## Timing
- Reset (async assert, sync-to-clk deassert by the system): state=IDLE, rd_addr=0, out_valid=0, out_data=0, out_index=0, out_last=0, busy=0, done=0.
- Reset mid-dump: all outputs go to the reset values immediately. No done pulse is produced.
- Start sampled at edge E0 -> LOAD during E0..E1 -> out_valid visible after E1.
- Throughput: one word per 2 cycles with out_ready tied high. A full 32-word dump takes 64 cycles from E0 to the final handshake edge. done is high for the cycle after that edge.
- Backpressure: each stalled cycle in SEND adds exactly one cycle; the data is held bit-stable.
- All outputs are registered except busy, which is decoded from state.

## Configuration
- REGDUMP_SKIP_ZERO_EN defined: the sweep starts at address 1. Register 0 is never read or emitted, so the dump is NUM_REGS-1 words (31 by default, 62 cycles with out_ready high). The first out_index is 1.
- Undefined: the sweep starts at address 0 and emits NUM_REGS words.
- Reset values, handshake and the last-word definition are identical in both builds.

## Test plan
- Preload reg[i]=32'hA5000000+i, out_ready=1, pulse start -> 32 words, out_index 0..31, out_data matching, out_last only on index 31, done pulses exactly 64 cycles after the start edge.
- Random out_ready (50%) -> same 32-word sequence with no drops or duplicates. out_data/out_index stay stable while out_valid&&!out_ready.
- abort asserted during SEND of index 10 with out_ready=1 in the same cycle -> out_valid low next cycle, no done, busy=0, rd_addr=0. A later start dumps from index 0 again.
- Register write of 32'hDEADBEEF to reg 5 at the LOAD edge for index 5 -> old value emitted. A second dump emits 32'hDEADBEEF.
- rst_n low mid-dump (index 20) -> all outputs zero asynchronously. start pulses during busy are ignored, checked by word count.
- With REGDUMP_SKIP_ZERO_EN -> 31 words, first out_index=1, out_last on 31, done 62 cycles after start.
